// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Single-port arbiter for the 64 KB byte-wide main memory, shared
//             between the 8-bit core and one secondary bus master (DMA or
//             video fetch). The core is stalled through cpu_hold while the
//             secondary master owns the bus. DMA grants are cut off after
//             MAX_BURST cycles so the core is never starved.
//  Config   : `MEM_ARB_FAIR_EN - when defined, at least CPU_MIN core-owned
//             cycles are enforced between two DMA grants. When undefined,
//             DMA has absolute priority and only MAX_BURST bounds a grant.
//  Params   : MAX_BURST - maximum consecutive DMA bus cycles per grant (>=1)
//             CPU_MIN   - minimum core cycles between two grants (>=1)
//  Ports    : clock, reset            - clock, synchronous active-high reset
//             cpu_address/out/we      - core bus request
//             cpu_in                  - read data to the core (= mem_in)
//             cpu_hold                - registered stall to the core
//             dma_req/address/out/we  - secondary master request
//             dma_last                - current granted cycle ends the burst
//             dma_gnt                 - registered, DMA owns the bus
//             dma_in                  - read data to DMA (= mem_in)
//             mem_address/out/we      - to memory array
//             mem_in                  - combinational read data from memory
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CPU_MIN   = 4
) (
  input  logic        clock,
  input  logic        reset,
  // core side
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_hold,
  // secondary master side
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_out,
  input  logic        dma_we,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [7:0]  dma_in,
  // memory side
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  input  logic [7:0]  mem_in
);

  // A burst counter of at least one bit keeps MAX_BURST = 1 legal; in that
  // case the counter is always 0 and every grant ends after one cycle.
  localparam int c_BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int c_QUOTA_W = $clog2(CPU_MIN + 1);

  localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST - 1);
  localparam logic [c_QUOTA_W-1:0] c_QUOTA_FULL = c_QUOTA_W'(CPU_MIN);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_cpu_hold;
  logic                   r_dma_gnt;
  logic [c_BURST_W-1:0]   r_burst;
  logic [c_QUOTA_W-1:0]   r_quota;

  logic                   w_quota_ok;
  logic                   w_burst_end;
  logic                   w_dma_sel;

  // Fairness gate: with the quota check enabled a request is only accepted
  // once the core has had its minimum share of the bus since the last grant.
`ifdef MEM_ARB_FAIR_EN
  assign w_quota_ok = (r_quota == c_QUOTA_FULL);
`else
  assign w_quota_ok = 1'b1;
`endif

  // A grant ends on the master's own last flag, on an abandoned request, or
  // when the burst limit is reached.
  assign w_burst_end = dma_last || !dma_req || (r_burst == c_BURST_LAST);

  // ------------------------------------------------------------------------
  // Arbitration FSM. cpu_hold and dma_gnt are registered alongside the state
  // so both masters see glitch-free ownership signals.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_CPU;
      r_cpu_hold <= 1'b0;
      r_dma_gnt  <= 1'b0;
      r_burst    <= '0;
      // Starting full lets the very first request through without waiting.
      r_quota    <= c_QUOTA_FULL;
    end else begin
      case (r_state)
        ST_CPU: begin
          if (r_quota != c_QUOTA_FULL) begin
            r_quota <= r_quota + 1'b1;
          end
          if (dma_req && w_quota_ok) begin
            r_state    <= ST_HOLD;
            r_cpu_hold <= 1'b1;
          end
        end

        // One handover cycle: the core still drives the bus so an access it
        // started before seeing hold completes cleanly.
        ST_HOLD: begin
          if (dma_req) begin
            r_state   <= ST_DMA;
            r_dma_gnt <= 1'b1;
            r_burst   <= '0;
          end else begin
            // Request abandoned: hand the bus back, keep the earned quota.
            r_state    <= ST_CPU;
            r_cpu_hold <= 1'b0;
          end
        end

        ST_DMA: begin
          if (w_burst_end) begin
            r_state    <= ST_CPU;
            r_dma_gnt  <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_quota    <= '0;
          end else begin
            r_burst <= r_burst + 1'b1;
          end
        end

        default: begin
          r_state    <= ST_CPU;
          r_cpu_hold <= 1'b0;
          r_dma_gnt  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Bus multiplexer. The core owns the bus in CPU and HOLD; DMA only in DMA.
  // A DMA write is suppressed if the request drops during a granted cycle.
  // ------------------------------------------------------------------------
  assign w_dma_sel   = (r_state == ST_DMA);

  assign mem_address = w_dma_sel ? dma_address : cpu_address;
  assign mem_out     = w_dma_sel ? dma_out     : cpu_out;
  assign mem_we      = w_dma_sel ? (dma_we & dma_req) : cpu_we;

  // Read data is shared; each master only uses it while it owns the bus.
  assign cpu_in      = mem_in;
  assign dma_in      = mem_in;

  assign cpu_hold    = r_cpu_hold;
  assign dma_gnt     = r_dma_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A per-cycle reference of
//             bus ownership is derived from the arbitration rules and pushed
//             into a scoreboard queue; a monitor on the falling edge pops and
//             compares against the DUT. A behavioural 64 KB memory is wired to
//             the memory port, mirrored by a reference copy.
//  Config   : `MEM_ARB_FAIR_EN selects the fair-quota reference behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TB_MAX_BURST = 4;
  localparam int TB_CPU_MIN   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic        cpu_hold;
  logic        dma_req;
  logic [15:0] dma_address;
  logic [7:0]  dma_out;
  logic        dma_we;
  logic        dma_last;
  logic        dma_gnt;
  logic [7:0]  dma_in;
  logic [15:0] mem_address;
  logic [7:0]  mem_out;
  logic        mem_we;
  logic [7:0]  mem_in;

  always #5 clock = ~clock;

  mem_arbiter #(
    .MAX_BURST (TB_MAX_BURST),
    .CPU_MIN   (TB_CPU_MIN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_address (cpu_address),
    .cpu_out     (cpu_out),
    .cpu_we      (cpu_we),
    .cpu_in      (cpu_in),
    .cpu_hold    (cpu_hold),
    .dma_req     (dma_req),
    .dma_address (dma_address),
    .dma_out     (dma_out),
    .dma_we      (dma_we),
    .dma_last    (dma_last),
    .dma_gnt     (dma_gnt),
    .dma_in      (dma_in),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .mem_we      (mem_we),
    .mem_in      (mem_in)
  );

  // Physical memory array: combinational read, write on the rising edge.
  logic [7:0] mem_arr [0:65535];
  assign mem_in = mem_arr[mem_address];
  always @(posedge clock) begin
    if (mem_we === 1'b1) mem_arr[mem_address] <= mem_out;
  end

  // ------------------------------------------------------------------------
  // Reference model and scoreboard
  // ------------------------------------------------------------------------
  typedef struct {
    logic        hold;
    logic        gnt;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] ref_mem [0:65535];

  // Ownership of the bus: 0 = core, 1 = handover cycle, 2 = DMA owns.
  int m_phase;
  int m_used;      // DMA cycles already spent in the current grant
  int m_core_run;  // core-state cycles since the last grant ended
  bit m_fair;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7) ^ (a >> 8));
  endfunction

  // Drive one cycle of inputs, record what the arbiter must present during
  // this cycle, then advance the reference to the next edge.
  task automatic step(input logic rst, input logic [15:0] ca, input logic [7:0] co,
                      input logic cwe, input logic req, input logic [15:0] da,
                      input logic [7:0] dd, input logic dwe, input logic last);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    cpu_address = ca;
    cpu_out     = co;
    cpu_we      = cwe;
    dma_req     = req;
    dma_address = da;
    dma_out     = dd;
    dma_we      = dwe;
    dma_last    = last;

    e.hold = (m_phase != 0);
    e.gnt  = (m_phase == 2);
    if (m_phase == 2) begin
      e.addr  = da;
      e.wdata = dd;
      e.we    = dwe && req;
    end else begin
      e.addr  = ca;
      e.wdata = co;
      e.we    = cwe;
    end
    e.rdata = ref_mem[e.addr];
    sb.push_back(e);
    if (e.we) ref_mem[e.addr] = e.wdata;

    if (rst) begin
      m_phase    = 0;
      m_used     = 0;
      m_core_run = TB_CPU_MIN;
    end else if (m_phase == 0) begin
      if (req && (!m_fair || m_core_run >= TB_CPU_MIN)) m_phase = 1;
      m_core_run++;
    end else if (m_phase == 1) begin
      m_phase = req ? 2 : 0;
      m_used  = 0;
    end else begin
      m_used++;
      if (last || !req || m_used >= TB_MAX_BURST) begin
        m_phase    = 0;
        m_core_run = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0100, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents its bus state, compare it.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("cpu_hold",    {15'b0, cpu_hold}, {15'b0, mon_e.hold});
      chk("dma_gnt",     {15'b0, dma_gnt},  {15'b0, mon_e.gnt});
      chk("mem_we",      {15'b0, mem_we},   {15'b0, mon_e.we});
      chk("mem_address", mem_address,       mon_e.addr);
      chk("mem_out",     {8'b0, mem_out},   {8'b0, mon_e.wdata});
      chk("cpu_in",      {8'b0, cpu_in},    {8'b0, mon_e.rdata});
      chk("dma_in",      {8'b0, dma_in},    {8'b0, mon_e.rdata});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    int  guard;
    bit  r_req;
`ifdef MEM_ARB_FAIR_EN
    m_fair = 1'b1;
`else
    m_fair = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) begin
      mem_arr[a] = init_byte(a);
      ref_mem[a] = init_byte(a);
    end
    reset = 1'b1; cpu_address = '0; cpu_out = '0; cpu_we = 1'b0;
    dma_req = 1'b0; dma_address = '0; dma_out = '0; dma_we = 1'b0; dma_last = 1'b0;
    m_phase = 0; m_used = 0; m_core_run = TB_CPU_MIN;

    // Reset, then a plain core write with no DMA activity.
    repeat (3) step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    step(1'b0, 16'h1234, 8'hA5, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    idle(3);
    chk("mem_1234", {8'b0, mem_arr[16'h1234]}, 16'h00A5);

    // Single DMA write with dma_last: request held through CPU, HOLD, DMA.
    repeat (3) step(1'b0, 16'h0200, 8'h11, 1'b0, 1'b1, 16'h8000, 8'h5A, 1'b1, 1'b1);
    idle(2);
    chk("mem_8000", {8'b0, mem_arr[16'h8000]}, 16'h005A);

    // Long burst: request held, never last, so MAX_BURST cuts each grant.
    for (int i = 0; i < 40; i++)
      step(1'b0, 16'h1220 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom),
           1'b1, 16'h1230 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom), 1'b0);
    idle(6);

    // Abandon in HOLD: one-cycle request.
    step(1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h9000, 8'h77, 1'b1, 1'b0);
    idle(6);

    // Reset in the third DMA cycle of a burst, request kept high afterwards.
    guard = 0;
    while (!(m_phase == 2 && m_used == 2) && guard < 60) begin
      step(1'b0, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h9100, 8'h33, 1'b1, 1'b0);
      guard++;
    end
    chk("reached_3rd_dma", {15'b0, (guard < 60)}, 16'h0001);
    step(1'b1, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h9101, 8'h34, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h9102, 8'h35, 1'b1, 1'b0);
    idle(6);

    // Randomized traffic with sticky requests, random last flags and resets.
    r_req = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (r_req) r_req = ($urandom_range(0, 99) < 85);
      else       r_req = ($urandom_range(0, 99) < 20);
      step(($urandom_range(0, 199) == 0),
           16'h1220 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom),
           r_req,
           16'h1230 + 16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0));
    end
    idle(2);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter for the 64 KB byte-wide main memory, shared between the 8-bit `core` and one secondary bus master (DMA / video fetch). It sits between both masters and the memory array, stalls the core through its `hold` input while the secondary master owns the bus, and bounds DMA bursts so the core is never starved. The memory array keeps its existing behaviour: combinational read data, write on the clock edge while `we` is high.

## Interface
- `MAX_BURST`, 16: maximum consecutive DMA bus cycles per grant (≥1).
- `CPU_MIN`, 4: minimum CPU-owned cycles between two DMA grants (≥1).

- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_address`  in  16  core address.
- `cpu_out`  in  8  core write data.
- `cpu_we`  in  1  core write enable.
- `cpu_in`  out  8  read data to core (= `mem_in`).
- `cpu_hold`  out  1  registered; drives core `hold`.
- `dma_req`  in  1  secondary master requests the bus; held until served or abandoned.
- `dma_address`  in  16  DMA address.
- `dma_out`  in  8  DMA write data.
- `dma_we`  in  1  DMA write enable.
- `dma_last`  in  1  current granted cycle is the last of the burst.
- `dma_gnt`  out  1  registered; DMA owns the bus this cycle.
- `dma_in`  out  8  read data to DMA (= `mem_in`).
- `mem_address`  out  16  to memory.
- `mem_out`  out  8  to memory.
- `mem_we`  out  1  to memory.
- `mem_in`  in  8  from memory.

## Operation
- States: `CPU`, `HOLD`, `DMA`.
- `CPU`: mux selects the core; `mem_we = cpu_we`; `quota` counts up, saturating at `CPU_MIN`. If `dma_req && quota == CPU_MIN` → `HOLD`, `cpu_hold` ← 1.
- `HOLD` (exactly one cycle): mux still selects the core so its in-flight access completes; `mem_we = cpu_we`. If `dma_req` still high → `DMA`, `dma_gnt` ← 1, `burst` ← 0; else → `CPU`, `cpu_hold` ← 0, `quota` unchanged.
- `DMA`: mux selects DMA; `mem_we = dma_we`; `burst` increments. Exit to `CPU` (`dma_gnt` ← 0, `cpu_hold` ← 0, `quota` ← 0) when `dma_last`, or `!dma_req`, or `burst == MAX_BURST-1`. If `dma_req` is low in a `DMA` cycle, `mem_we` is forced 0.
- `dma_we`/`dma_address` are ignored outside `DMA`; `cpu_we` is ignored in `DMA`.
- `burst` is `$clog2(MAX_BURST)` bits wide, `quota` is `$clog2(CPU_MIN+1)` bits wide; neither wraps.

## Timing
- Reset values: state `CPU`, `cpu_hold` 0, `dma_gnt` 0, `burst` 0, `quota` = `CPU_MIN` (first request is served without waiting).
- Request latency: `dma_req` sampled high in `CPU` at edge N → `cpu_hold` = 1 after N, `dma_gnt` = 1 after N+1; first DMA access occupies cycle N+2.
- Burst of L cycles (L ≤ `MAX_BURST`): `dma_gnt` high for exactly L cycles; the core resumes in the cycle after the last DMA cycle.
- Back-to-back requests: at least `CPU_MIN` core cycles between consecutive grants.
- `MAX_BURST = 1`: every grant is a single cycle regardless of `dma_last`.
- Reset asserted in any state: next cycle is `CPU` with `cpu_hold` = 0 and `dma_gnt` = 0; no write is issued in the reset cycle beyond the selected master's combinational `mem_we`.
- Read data is combinational: `cpu_in = dma_in = mem_in` in every cycle.

## Configuration
- `MEM_ARB_FAIR_EN` defined: `CPU_MIN` quota enforced as above.
- Not defined: the quota check is removed and DMA has absolute priority. `dma_req` in `CPU` always → `HOLD`. `MAX_BURST` still limits each grant; a still-asserted request re-enters `HOLD` on the very next cycle after `CPU`.

## Test plan
- Reset, no DMA: core drives address 0x1234, we = 1, data 0xA5 → `mem_*` mirror core, memory[0x1234] = 0xA5, `cpu_hold` = 0.
- Single DMA write: `dma_req` at cycle 10 with address 0x8000, data 0x5A, `dma_last` = 1 → `cpu_hold` from 11, `dma_gnt` only in cycle 12, memory[0x8000] = 0x5A, hold released in 13.
- Long burst: `dma_req` held with `dma_last` = 0, `MAX_BURST` = 16 → `dma_gnt` exactly 16 cycles, then with `MEM_ARB_FAIR_EN` ≥ 4 core cycles, then re-grant.
- Abandon in HOLD: `dma_req` for one cycle only → `cpu_hold` pulses one cycle, `dma_gnt` never asserts, state returns to `CPU`.
- Reset mid-burst: assert `reset` in the 3rd DMA cycle → next cycle `dma_gnt` = 0, `cpu_hold` = 0, and a pending request is granted again after 2 more cycles.
- Without `MEM_ARB_FAIR_EN`: continuous `dma_req`, `MAX_BURST` = 4 → pattern of 4 DMA, 1 CPU, 1 HOLD cycles, repeated.
